burst_line_ram: RTL and testbench
=================================

Name: burst_line_ram

Overview:
- Parametrised synchronous backing memory for the direct-mapped cache.
- Serves whole cache lines as multi-beat bursts: line fills on read, write-backs on write.
- Programmable access latency, valid/ready handshakes on request, write-data and read-data channels.
- Sits between the cache controller and the memory array.
- Replaces the single-word, single-cycle RAM with a line-oriented memory.

Parameters:
- DATA_W, 32: word width in bits.
- ADDR_W, 10: word address width; depth is 2**ADDR_W words.
- BURST_LEN, 4: words per line; power of two, 2..16.
- RD_LAT, 2: cycles from request acceptance to first read beat; range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = line write, 0 = line read.
- req_addr  in  ADDR_W  word address inside the target line.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat present.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  marks final read beat.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. wr_ready=0, rd_valid=0, rd_last=0, busy=0, rd_data=0.
- Array is zero-initialised at elaboration for all 2**ADDR_W entries. Reset does not clear the array.
- Line base is req_addr with the low log2(BURST_LEN) bits cleared. Beat index is a log2(BURST_LEN)-bit counter. Beat address = base | beat index, so it wraps inside the line and never crosses into the neighbouring line.
- IDLE state:
  - req_ready=1.
  - On accept with req_we=1: latch base and go to WBURST.
  - On accept with req_we=0: latch base, load latency counter with RD_LAT-1, go to RWAIT.
- WBURST state:
  - wr_ready=1.
  - Each accepted beat writes the word at its beat address on the same edge, then the beat index increments.
  - After beat BURST_LEN-1 is accepted, return to IDLE. The next request can be accepted on the following cycle.
  - wr_valid outside WBURST is ignored, with no write.
- RWAIT state:
  - Counter decrements each cycle. At 0, issue the synchronous array read for beat 0.
  - rd_valid rises exactly RD_LAT cycles after the accept edge.
- RBURST state:
  - rd_valid=1 and rd_data holds the current beat. rd_last=1 on beat BURST_LEN-1.
  - While rd_ready=0, rd_data and rd_last are held stable and the array is not re-read.
  - With rd_ready held at 1, one beat is delivered per cycle with no bubbles. Prefetch the next word, or use a skid register, to achieve this.
  - After the last beat handshake, return to IDLE with rd_valid=0 on the next cycle.
- Only one outstanding request. req_ready=0 in every non-IDLE state.
- Reset mid-burst: return to IDLE next cycle and drop rd_valid/wr_ready. Write beats already accepted remain in memory; the remaining words of the line are unchanged.
- A write to a line is visible to any read accepted after the write burst completes.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: the read beat index starts at req_addr[log2(BURST_LEN)-1:0] and wraps modulo BURST_LEN. rd_last sits on the beat before the start index. Write bursts are unchanged and always start at index 0.
- Undefined: reads always start at index 0, and the low address bits are ignored for both reads and writes.

Decomposition:
- Shared package burst_ram_pkg holds:
  - state enum IDLE, WBURST, RWAIT, RBURST;
  - localparam helper for beat-index width, $clog2(BURST_LEN);
  - default parameter constants shared with the cache controller.
- One sub-module, burst_ram_array: plain posedge single-port synchronous RAM with w_en, r_en, addr, data_in and registered data_o. The FSM, counters and skid logic live in burst_line_ram.

Test Plan:
- Write then read, defaults:
  - Write line at req_addr=0x014 with data 0xA0..0xA3 → mem[0x14..0x17] = A0..A3.
  - Read at req_addr=0x015 (feature off) → rd_valid 2 cycles after accept; beats A0, A1, A2, A3; rd_last on A3.
- Read backpressure:
  - Drop rd_ready for 3 cycles on beat 1 → rd_data stays A1 and rd_valid stays 1 throughout; 4 beats total; no duplicated or skipped beats.
- Latency sweep, RD_LAT in 1, 4, 15:
  - First rd_valid exactly RD_LAT cycles after accept.
  - req_ready=0 for the whole burst; a second req_valid in that window is not accepted.
- Wrap, with CRITICAL_WORD_FIRST_EN defined:
  - Read at 0x017 → beats A3, A0, A1, A2; rd_last on A2.
  - Address 0x3FF with base 0x3FC → no access outside 0x3FC..0x3FF.
- Reset mid-operation:
  - Assert rst after 2 of 4 write beats (B0, B1) into a line holding A0..A3 → line reads B0, B1, A2, A3.
  - After rst, all outputs at reset values and req_ready=1 one cycle after rst falls.
- Zero init and idle writes:
  - Read any untouched line → all beats 0.
  - wr_valid pulsed in IDLE → no memory change.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared types and defaults for the burst line RAM and the cache controller that drives it.
// No logic lives here: it holds the FSM state encoding, default parameter values and the beat-index width helper.
// Backpressure behaviour is defined by the modules that import this package.
package burst_ram_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_RD_LAT    = 2;

  // Wide enough for the largest supported latency preload (RD_LAT-1 = 14).
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WBURST,
    RWAIT,
    RBURST
  } state_t;

  function automatic int beat_idx_w(input int burst_len);
    return $clog2(burst_len);
  endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port synchronous RAM, zero-filled at elaboration and not cleared by reset.
// Writes land on the clock edge; data_o is registered and updates one edge after r_en.
// No backpressure: data_o holds its value on any cycle where r_en is low.
module burst_ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (w_en) mem[addr] <= data_in;
    if (r_en) data_o <= mem[addr];
  end

endmodule

// File: rtl/burst_line_ram.sv
// Line-oriented backing memory: whole-line write bursts and read bursts; CRITICAL_WORD_FIRST_EN starts reads at the requested word.
// Latency: first read beat RD_LAT cycles after request accept, then one beat per cycle; a write beat lands on its accept edge.
// Backpressure: a read beat holds while rd_ready is low, with no array re-read; one request outstanding, req_ready low while busy.
module burst_line_ram
  import burst_ram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy
);

  localparam int BW = beat_idx_w(BURST_LEN);
  localparam logic [BW-1:0]        LAST_IDX = BW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0]    OFS_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

  state_t                state;
  logic [ADDR_W-1:0]     base_q;
  logic [BW-1:0]         idx_q;
  logic [BW-1:0]         num_q;
  logic [LAT_CNT_W-1:0]  cnt_q;
  logic                  req_ready_q;
  logic                  wr_ready_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  busy_q;

  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_issue;
  logic                  rd_next;
  logic [BW-1:0]         rd_start;
  logic                  arr_we;
  logic                  arr_re;
  logic [ADDR_W-1:0]     arr_addr;
  logic [DATA_W-1:0]     arr_q;

`ifdef CRITICAL_WORD_FIRST_EN
  assign rd_start = req_addr[BW-1:0];
`else
  assign rd_start = '0;
`endif

  assign req_fire = req_valid & req_ready_q;
  assign wr_fire  = wr_valid & wr_ready_q;
  assign rd_fire  = rd_valid_q & rd_ready;
  assign rd_issue = (state == RWAIT) && (cnt_q == '0);
  // Prefetch the next beat on each handshake so the array output already holds it next cycle.
  assign rd_next  = rd_fire && (num_q != LAST_IDX);

  assign arr_we   = wr_fire & ~rst;
  assign arr_re   = (rd_issue | rd_next) & ~rst;
  assign arr_addr = base_q | ADDR_W'(idx_q);

  burst_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .w_en    (arr_we),
    .r_en    (arr_re),
    .addr    (arr_addr),
    .data_in (wr_data),
    .data_o  (arr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_fire) begin
            base_q      <= req_addr & ~OFS_MASK;
            num_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_we) begin
              state      <= WBURST;
              idx_q      <= '0;
              wr_ready_q <= 1'b1;
            end else begin
              state <= RWAIT;
              idx_q <= rd_start;
              cnt_q <= LAT_INIT;
            end
          end
        end
        WBURST: begin
          if (wr_fire) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state       <= IDLE;
              wr_ready_q  <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        RWAIT: begin
          if (cnt_q == '0) begin
            state      <= RBURST;
            idx_q      <= idx_q + 1'b1;
            num_q      <= '0;
            rd_valid_q <= 1'b1;
            rd_last_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RBURST: begin
          if (rd_ready) begin
            if (num_q == LAST_IDX) begin
              state       <= IDLE;
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q     <= idx_q + 1'b1;
              num_q     <= num_q + 1'b1;
              rd_last_q <= (num_q == LAST_IDX - 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign rd_data   = rd_valid_q ? arr_q : '0;

endmodule

// File: tb/tb_burst_line_ram.sv
// Directed bench for burst_line_ram: expected read beats are queued as requests are issued and a monitor checks every handshake.
// Three extra instances measure first-beat latency for RD_LAT 1, 4 and 15.
module tb_burst_line_ram;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BL = 4;

  typedef logic [DW-1:0] line_t [BL];
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;

  always #5 clk = ~clk;

  burst_line_ram #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  // Latency-sweep instances: read-only, always ready to consume.
  logic [2:0]    lv = 3'b000;
  logic          lrr [3];
  logic          lwr [3];
  logic          lrv [3];
  logic          lrl [3];
  logic          lbusy [3];
  logic [DW-1:0] lrd [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_lat
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 15);
      burst_line_ram #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .RD_LAT(L)) u_lat (
        .clk(clk), .rst(rst), .req_valid(lv[g]), .req_ready(lrr[g]), .req_we(1'b0),
        .req_addr(10'h014), .wr_valid(1'b0), .wr_ready(lwr[g]), .wr_data('0),
        .rd_valid(lrv[g]), .rd_ready(1'b1), .rd_data(lrd[g]), .rd_last(lrl[g]), .busy(lbusy[g])
      );
    end
  endgenerate

  int    checks = 0;
  int    passes = 0;
  beat_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pops one expected beat per handshake and checks stability across stalls.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else if (rd_valid) begin
      if (prev_stall) begin
        check("stall_hold_data", rd_data, prev_data);
        check("stall_hold_last", 32'(rd_last), 32'(prev_last));
      end
      if (rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", 32'(rd_last), 32'(e.last));
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = rd_data;
        prev_last  = rd_last;
      end
    end else begin
      if (prev_stall) check("stall_hold_valid", 32'(rd_valid), 32'd1);
      prev_stall = 1'b0;
    end
  end

  task automatic send_req(input logic we, input logic [AW-1:0] a);
    bit ok;
    int t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    do begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 50);
    #1 req_valid = 1'b0;
    if (!ok) timeout("req_accept");
  endtask

  task automatic write_beat(input logic [DW-1:0] d);
    bit ok;
    int t = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    do begin
      @(negedge clk);
      ok = wr_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 50);
    #1 wr_valid = 1'b0;
    if (!ok) timeout("wr_accept");
  endtask

  task automatic write_line(input logic [AW-1:0] a, input line_t d, input int n);
    send_req(1'b1, a);
    for (int i = 0; i < n; i++) write_beat(d[i]);
  endtask

  task automatic read_line(input logic [AW-1:0] a, input line_t line, input int stall);
    int    s;
    int    lat;
    int    t;
    beat_t b;
`ifdef CRITICAL_WORD_FIRST_EN
    s = int'(a[1:0]);
`else
    s = 0;
`endif
    for (int k = 0; k < BL; k++) begin
      b.data = line[(s + k) % BL];
      b.last = (k == BL - 1);
      exp_q.push_back(b);
    end
    send_req(1'b0, a);
    lat = 0;
    @(negedge clk);
    while (!rd_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rd_latency", 32'(lat), 32'd2);
    check("busy_during_read", 32'(busy), 32'd1);
    check("req_ready_during_read", 32'(req_ready), 32'd0);
    if (stall > 0) begin
      @(posedge clk);
      #1 rd_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1 rd_ready = 1'b1;
    end
    t = 0;
    while (!(rd_valid && rd_ready && rd_last) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) timeout("rd_last_beat");
    @(negedge clk);
    check("rd_valid_after_last", 32'(rd_valid), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    line_t la, lb, lc, ld, lz, lm;
    int    lats [3];
    int    first [3];
    int    beats [3];
    bit    bad [3];
    bit    done [3];

    la = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    lb = '{32'hB0, 32'hB1, 32'h0, 32'h0};
    lc = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    ld = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    lz = '{32'h0, 32'h0, 32'h0, 32'h0};
    lm = '{32'hB0, 32'hB1, 32'hA2, 32'hA3};
    lats = '{1, 4, 15};

    // Reset values and req_ready rising one cycle after reset release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("req_ready_at_release", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("req_ready_after_release", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Untouched line reads zero; write beats offered in IDLE change nothing.
    read_line(10'h100, lz, 0);
    wr_valid = 1'b1;
    wr_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_ready_idle", 32'(wr_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 wr_valid = 1'b0;
    read_line(10'h100, lz, 0);

    // Write then read, including a 3-cycle stall on beat 1 and an offset start.
    write_line(10'h000, ld, BL);
    write_line(10'h014, la, BL);
    read_line(10'h015, la, 0);
    read_line(10'h014, la, 3);
    read_line(10'h017, la, 0);

    // Top line: beats must wrap inside 0x3FC..0x3FF and leave line 0x000 alone.
    write_line(10'h3FC, lc, BL);
    read_line(10'h3FF, lc, 0);
    read_line(10'h000, ld, 0);

    // Reset after two of four write beats.
    write_line(10'h014, lb, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_ready", 32'(wr_ready), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("midrst_req_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    read_line(10'h014, lm, 0);

    // Latency sweep; req_valid stays high through each burst to probe for a second accept.
    for (int i = 0; i < 3; i++) begin
      first[i] = -1;
      beats[i] = 0;
      bad[i]   = 1'b0;
      done[i]  = 1'b0;
    end
    @(posedge clk);
    #1 lv = 3'b111;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!done[i]) begin
          if (lrr[i] || lwr[i] || !lbusy[i]) bad[i] = 1'b1;
          if (lrv[i]) begin
            if (first[i] < 0) first[i] = c;
            beats[i]++;
            if (lrd[i] != '0) bad[i] = 1'b1;
            if (lrl[i]) begin
              done[i] = 1'b1;
              lv[i]   = 1'b0;
            end
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat%0d_first_beat", lats[i]), 32'(first[i]), 32'(lats[i]));
      check($sformatf("lat%0d_beats", lats[i]), 32'(beats[i]), 32'(BL));
      check($sformatf("lat%0d_busy_window", lats[i]), 32'(bad[i]), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
